// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL reset, syncs locked,
// and sequences system then CPU reset release.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_PULSE  = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int STAGE_DELAY  = 256,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_sys,
  output logic       rst_cpu,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int M0 = (RESET_PULSE > LOCK_STABLE)
                    ? RESET_PULSE : LOCK_STABLE;
  localparam int M1 = (STAGE_DELAY > LOCK_TIMEOUT)
                    ? STAGE_DELAY : LOCK_TIMEOUT;
  localparam int MAXP = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] LD_RST  = CW'(RESET_PULSE - 1);
  localparam logic [CW-1:0] LD_WAIT = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_STAB = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] LD_REL  = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] LD_INIT = CW'(RESET_PULSE);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_REL_SYS,
    S_RUN,
    S_LOSS
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] retry_q, retry_d;
  logic [7:0] loss_q, loss_d;
  logic pll_rst_q, pll_rst_d;
  logic rst_sys_q, rst_sys_d;
  logic rst_cpu_q, rst_cpu_d;
  logic ready_q, ready_d;
  logic locked_s;
  logic cnt_zero;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_zero) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LD_WAIT;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = LD_STAB;
        end else if (cnt_zero) begin
          state_d = S_PLL_RST;
          cnt_d   = LD_RST;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      S_STABLE: begin
        // a drop always beats an expiring count
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LD_WAIT;
        end else if (cnt_zero) begin
          state_d = S_REL_SYS;
          cnt_d   = LD_REL;
        end
      end
      S_REL_SYS: begin
        if (!locked_s) begin
          state_d = S_LOSS;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_LOSS;
          cnt_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      S_LOSS: begin
        state_d = S_PLL_RST;
        cnt_d   = LD_RST;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = LD_RST;
      end
    endcase
  end

  always_comb begin
    pll_rst_d = 1'b0;
    rst_sys_d = 1'b1;
    rst_cpu_d = 1'b1;
    ready_d   = 1'b0;
    unique case (1'b1)
      (state_d == S_PLL_RST): pll_rst_d = 1'b1;
      (state_d == S_REL_SYS): rst_sys_d = 1'b0;
      (state_d == S_RUN): begin
        rst_sys_d = 1'b0;
        rst_cpu_d = 1'b0;
        ready_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_PLL_RST;
      sync_q    <= '0;
      // the reset edge itself counts as an extra PLL_RST cycle
      cnt_q     <= LD_INIT;
      retry_q   <= 8'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      rst_sys_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      rst_sys_q <= rst_sys_d;
      rst_cpu_q <= rst_cpu_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_sys       = rst_sys_q;
  assign rst_cpu       = rst_cpu_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; cycle k
// means the value just after the k-th edge past reset.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       pll_rst;
  logic       rst_sys;
  logic       rst_cpu;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;

  int n_chk;
  int n_err;
  int cyc;

  pll_lock_supervisor #(
    .SYNC_STAGES (2),
    .RESET_PULSE (4),
    .LOCK_STABLE (8),
    .STAGE_DELAY (4),
    .LOCK_TIMEOUT(32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .rst_sys      (rst_sys),
    .rst_cpu      (rst_cpu),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d got %0d exp %0d",
               tag, cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    check("rst_pll_rst", pll_rst, 1);
    check("rst_rst_sys", rst_sys, 1);
    check("rst_rst_cpu", rst_cpu, 1);
    check("rst_ready", ready, 0);
    check("rst_loss", lock_loss_cnt, 0);
    check("rst_retry", retry_cnt, 0);
    reset_n = 1'b1;
    cyc = -1;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    cyc     = -10;
    reset_n = 1'b0;
    locked  = 1'b0;
    tick();

    // clean bring-up
    do_reset();
    run_to(3);  check("bu_pll_hi", pll_rst, 1);
    run_to(4);  check("bu_pll_lo", pll_rst, 0);
    run_to(10); locked = 1'b1;
    run_to(20); check("bu_sys_hold", rst_sys, 1);
    run_to(21); check("bu_sys_rel", rst_sys, 0);
    check("bu_cpu_hold", rst_cpu, 1);
    run_to(24); check("bu_rdy_lo", ready, 0);
    run_to(25); check("bu_cpu_rel", rst_cpu, 0);
    check("bu_rdy_hi", ready, 1);
    check("bu_retry", retry_cnt, 0);
    check("bu_loss", lock_loss_cnt, 0);

    // lock loss in RUN, then recovery
    run_to(40); locked = 1'b0;
    run_to(42); check("ll_rdy_still", ready, 1);
    run_to(43); check("ll_sys_hi", rst_sys, 1);
    check("ll_cpu_hi", rst_cpu, 1);
    check("ll_rdy_lo", ready, 0);
    check("ll_pll_lo", pll_rst, 0);
    run_to(44); check("ll_pll_hi", pll_rst, 1);
    check("ll_cnt", lock_loss_cnt, 1);
    run_to(50); locked = 1'b1;
    run_to(60); check("ll_sys_hold", rst_sys, 1);
    run_to(61); check("ll_sys_rel", rst_sys, 0);
    run_to(65); check("ll_rdy_hi", ready, 1);
    check("ll_cnt_keep", lock_loss_cnt, 1);

    // reset mid-RUN with locked held high
    run_to(70);
    do_reset();
    run_to(3);  check("mr_pll_hi", pll_rst, 1);
    run_to(4);  check("mr_pll_lo", pll_rst, 0);
    run_to(12); check("mr_sys_hold", rst_sys, 1);
    run_to(13); check("mr_sys_rel", rst_sys, 0);
    run_to(17); check("mr_rdy_hi", ready, 1);

    // one-cycle glitch while in STABLE
    locked = 1'b0;
    do_reset();
    run_to(10); locked = 1'b1;
    run_to(15); locked = 1'b0;
    run_to(16); locked = 1'b1;
    run_to(21); check("gl_no_rel", rst_sys, 1);
    run_to(26); check("gl_sys_hold", rst_sys, 1);
    run_to(27); check("gl_sys_rel", rst_sys, 0);
    check("gl_loss", lock_loss_cnt, 0);

    // drop exactly as REL_SYS count expires
    locked = 1'b0;
    do_reset();
    run_to(10); locked = 1'b1;
    run_to(21); check("dw_sys_rel", rst_sys, 0);
    run_to(22); locked = 1'b0;
    run_to(24); check("dw_sys_still", rst_sys, 0);
    run_to(25); check("dw_no_rdy", ready, 0);
    check("dw_sys_hi", rst_sys, 1);
    check("dw_cpu_hi", rst_cpu, 1);
    run_to(26); check("dw_pll_hi", pll_rst, 1);
    check("dw_loss", lock_loss_cnt, 0);

    // timeout retries and saturation
    do_reset();
    run_to(35);  check("to_pll_lo", pll_rst, 0);
    check("to_retry0", retry_cnt, 0);
    run_to(36);  check("to_pll_hi", pll_rst, 1);
    check("to_retry1", retry_cnt, 1);
    run_to(39);  check("to_pll_hi3", pll_rst, 1);
    run_to(40);  check("to_pll_lo2", pll_rst, 0);
    run_to(71);  check("to_retry1b", retry_cnt, 1);
    run_to(72);  check("to_retry2", retry_cnt, 2);
    check("to_pll_hi2", pll_rst, 1);
    run_to(108); check("to_retry3", retry_cnt, 3);
    check("to_sys_hi", rst_sys, 1);
    run_to(9179);  check("sat_254", retry_cnt, 254);
    run_to(9180);  check("sat_255", retry_cnt, 255);
    run_to(10800); check("sat_300", retry_cnt, 255);
    run_to(10836); check("sat_301", retry_cnt, 255);
    check("sat_sys_hi", rst_sys, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
